// File: rtl/pipe_pkg.sv
// Shared types for the integer pipeline hazard controller: scoreboard entry layout,
// the empty (NOP) entry and small helpers used by the controller and its matcher.
package pipe_pkg;

  // Destination fields are zero-extended to this width, so REG_ADDR_WIDTH must not exceed it.
  localparam int RD_MAX_WIDTH = 8;

  typedef struct packed {
    logic                    valid;
    logic [RD_MAX_WIDTH-1:0] rd;
    logic                    reg_write;
    logic                    mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_NOP = '0;

  function automatic int sel_width(input int mem_stages);
    return $clog2(mem_stages + 2);
  endfunction

  // An entry only counts as a producer if it really writes a non-zero register.
  function automatic logic sb_writes(input sb_entry_t e);
    return e.valid && e.reg_write && (e.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Per-source matcher: load-use hit for an ID source and forwarding select for an EX source,
// both evaluated against the scoreboard (index 0 = EX, k = Mk, MEM_STAGES+1 = WB).
module pipe_hazard_cmp
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_STAGES     = 1,
  parameter int SEL_WIDTH      = sel_width(MEM_STAGES)
) (
  input  logic                      hit_en,
  input  logic [REG_ADDR_WIDTH-1:0] hit_addr,
  input  logic                      fwd_en,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  input  sb_entry_t                 sb [MEM_STAGES+2],
  output logic                      load_hit,
  output logic [SEL_WIDTH-1:0]      fwd_sel
);

  localparam int ENTRIES = MEM_STAGES + 2;

  logic [ENTRIES-1:0] hit_vec;
  logic [ENTRIES-1:0] fwd_vec;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_match
      // A load is still unusable while it sits in EX..M(n-1).
      if (gi < MEM_STAGES) begin : g_hit
        assign hit_vec[gi] = hit_en && sb[gi].mem_read && sb_writes(sb[gi]) &&
                             (sb[gi].rd == RD_MAX_WIDTH'(hit_addr));
      end else begin : g_no_hit
        assign hit_vec[gi] = 1'b0;
      end

      if (gi >= 1) begin : g_fwd
        assign fwd_vec[gi] = fwd_en && sb_writes(sb[gi]) &&
                             (sb[gi].rd == RD_MAX_WIDTH'(fwd_addr));
      end else begin : g_no_fwd
        assign fwd_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign load_hit = |hit_vec;

  // Walk oldest to youngest so the youngest matching producer wins; a load short of WB yields 0.
  always_comb begin
    fwd_sel = '0;
    for (int i = ENTRIES - 1; i >= 1; i--) begin
      if (fwd_vec[i]) begin
        fwd_sel = (sb[i].mem_read && (i != ENTRIES - 1)) ? '0 : SEL_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall/flush controller for the ID->EX->M1..Mn->WB pipeline: shift-register
// scoreboard, load-use stalls, memory-wait freezes, branch flushes, EX forwarding, perf counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_STAGES     = 1,
  parameter int SEL_WIDTH      = sel_width(MEM_STAGES),
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_rs1_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic                      id_rs2_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      branch_taken,
  input  logic                      dmem_ready,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      flush_if_id,
  output logic                      freeze_mem,
  output logic                      bubble_wb,
  output logic [SEL_WIDTH-1:0]      fwd_sel_op1,
  output logic [SEL_WIDTH-1:0]      fwd_sel_op2,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int ENTRIES = MEM_STAGES + 2;

  sb_entry_t                 sb_reg [ENTRIES];
  logic                      ex_rs1_en_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_reg;
  logic                      ex_rs2_en_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_reg;
  logic [CNT_WIDTH-1:0]      stall_cnt_reg;
  logic [CNT_WIDTH-1:0]      flush_cnt_reg;

  logic                 hit_rs1, hit_rs2;
  logic [SEL_WIDTH-1:0] sel_rs1, sel_rs2;
  logic                 mem_wait, load_use;
  sb_entry_t            id_entry;

  pipe_hazard_cmp #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .MEM_STAGES    (MEM_STAGES),
    .SEL_WIDTH     (SEL_WIDTH)
  ) u_cmp_rs1 (
    .hit_en  (id_valid && id_rs1_en),
    .hit_addr(id_rs1_addr),
    .fwd_en  (sb_reg[0].valid && ex_rs1_en_reg),
    .fwd_addr(ex_rs1_addr_reg),
    .sb      (sb_reg),
    .load_hit(hit_rs1),
    .fwd_sel (sel_rs1)
  );

  pipe_hazard_cmp #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .MEM_STAGES    (MEM_STAGES),
    .SEL_WIDTH     (SEL_WIDTH)
  ) u_cmp_rs2 (
    .hit_en  (id_valid && id_rs2_en),
    .hit_addr(id_rs2_addr),
    .fwd_en  (sb_reg[0].valid && ex_rs2_en_reg),
    .fwd_addr(ex_rs2_addr_reg),
    .sb      (sb_reg),
    .load_hit(hit_rs2),
    .fwd_sel (sel_rs2)
  );

  assign mem_wait = !dmem_ready;
  assign load_use = hit_rs1 || hit_rs2;

  always_comb begin
    id_entry           = SB_NOP;
    id_entry.valid     = id_valid;
    id_entry.rd        = RD_MAX_WIDTH'(id_rd_addr);
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
  end

  // Mem wait outranks load-use, which outranks a taken branch.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    freeze_mem  = 1'b0;
    bubble_wb   = 1'b0;
    fwd_sel_op1 = '0;
    fwd_sel_op2 = '0;
    if (!rst) begin
      fwd_sel_op1 = sel_rs1;
      fwd_sel_op2 = sel_rs2;
      if (mem_wait) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        freeze_mem = 1'b1;
        bubble_wb  = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end else if (id_valid && branch_taken) begin
        flush_if_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) sb_reg[i] <= SB_NOP;
      ex_rs1_en_reg   <= 1'b0;
      ex_rs1_addr_reg <= '0;
      ex_rs2_en_reg   <= 1'b0;
      ex_rs2_addr_reg <= '0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      if (mem_wait) begin
        sb_reg[ENTRIES-1] <= SB_NOP;
      end else begin
        for (int i = 1; i < ENTRIES; i++) sb_reg[i] <= sb_reg[i-1];
        sb_reg[0]       <= load_use ? SB_NOP : id_entry;
        ex_rs1_en_reg   <= id_valid && !load_use && id_rs1_en;
        ex_rs1_addr_reg <= id_rs1_addr;
        ex_rs2_en_reg   <= id_valid && !load_use && id_rs2_en;
        ex_rs2_addr_reg <= id_rs2_addr;
      end
      if (stall_if)    stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_if_id) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (1 and 3 memory stages) share stimulus and are
// compared every cycle against a pool-of-instructions reference model.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid, id_rs1_en, id_rs2_en, id_reg_write, id_mem_read;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       branch_taken, dmem_ready;

  logic        d0_sif, d0_sid, d0_bex, d0_fl, d0_fz, d0_bwb;
  logic [1:0]  d0_sel1, d0_sel2;
  logic [31:0] d0_scnt, d0_fcnt;
  logic        d1_sif, d1_sid, d1_bex, d1_fl, d1_fz, d1_bwb;
  logic [2:0]  d1_sel1, d1_sel2;
  logic [31:0] d1_scnt, d1_fcnt;

  pipeline_ctrl #(.MEM_STAGES(1)) u_dut_n1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .stall_if(d0_sif), .stall_id(d0_sid), .bubble_ex(d0_bex), .flush_if_id(d0_fl),
    .freeze_mem(d0_fz), .bubble_wb(d0_bwb), .fwd_sel_op1(d0_sel1), .fwd_sel_op2(d0_sel2),
    .stall_cnt(d0_scnt), .flush_cnt(d0_fcnt)
  );

  pipeline_ctrl #(.MEM_STAGES(3)) u_dut_n3 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .stall_if(d1_sif), .stall_id(d1_sid), .bubble_ex(d1_bex), .flush_if_id(d1_fl),
    .freeze_mem(d1_fz), .bubble_wb(d1_bwb), .fwd_sel_op1(d1_sel1), .fwd_sel_op2(d1_sel2),
    .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt)
  );

  always #5 clk = ~clk;

  // Observed outputs, control bits ordered {stall_if, stall_id, bubble_ex, flush, freeze, bubble_wb}.
  logic [5:0]  ctl_obs  [2];
  logic [2:0]  sel1_obs [2];
  logic [2:0]  sel2_obs [2];
  logic [31:0] scnt_obs [2];
  logic [31:0] fcnt_obs [2];
  assign ctl_obs[0]  = {d0_sif, d0_sid, d0_bex, d0_fl, d0_fz, d0_bwb};
  assign ctl_obs[1]  = {d1_sif, d1_sid, d1_bex, d1_fl, d1_fz, d1_bwb};
  assign sel1_obs[0] = {1'b0, d0_sel1};
  assign sel2_obs[0] = {1'b0, d0_sel2};
  assign sel1_obs[1] = d1_sel1;
  assign sel2_obs[1] = d1_sel2;
  assign scnt_obs[0] = d0_scnt;
  assign scnt_obs[1] = d1_scnt;
  assign fcnt_obs[0] = d0_fcnt;
  assign fcnt_obs[1] = d1_fcnt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an unordered pool of in-flight instructions, each tagged with the
  // pipeline stage it occupies (0 = EX, k = Mk, n+1 = WB).
  localparam int POOL = 16;
  bit        m_live [2][POOL];
  int        m_stage[2][POOL];
  int        m_rd   [2][POOL];
  bit        m_rw   [2][POOL];
  bit        m_mr   [2][POOL];
  bit        m_s1en [2][POOL];
  int        m_s1   [2][POOL];
  bit        m_s2en [2][POOL];
  int        m_s2   [2][POOL];
  bit [31:0] m_stall[2];
  bit [31:0] m_flush[2];

  function automatic int exp_sel(input int d, input int n, input bit en, input int src);
    int best;
    int sel;
    best = 1000;
    sel  = 0;
    if (!en || src == 0) return 0;
    for (int i = 0; i < POOL; i++) begin
      if (m_live[d][i] && m_stage[d][i] >= 1 && m_rw[d][i] && m_rd[d][i] == src &&
          m_stage[d][i] < best) begin
        best = m_stage[d][i];
        sel  = (m_mr[d][i] && m_stage[d][i] <= n) ? 0 : m_stage[d][i];
      end
    end
    return sel;
  endfunction

  task automatic drive(input bit r, input bit v, input bit e1, input int a1, input bit e2,
                       input int a2, input int rd, input bit w, input bit m, input bit b,
                       input bit rdy);
    rst          = r;
    id_valid     = v;
    id_rs1_en    = e1;
    id_rs1_addr  = 5'(a1);
    id_rs2_en    = e2;
    id_rs2_addr  = 5'(a2);
    id_rd_addr   = 5'(rd);
    id_reg_write = w;
    id_mem_read  = m;
    branch_taken = b;
    dmem_ready   = rdy;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    drive(0, 1, 1, rs1, 1, rs2, rd, 1, 0, 0, 1);
  endtask

  task automatic load(input int rd, input int rs1);
    drive(0, 1, 1, rs1, 0, 0, rd, 1, 1, 0, 1);
  endtask

  // Compare both DUTs against the model for the current inputs, then apply the clock edge.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int n;
      int ex;
      int s1;
      int s2;
      bit mw;
      bit lu;
      bit fl;
      bit placed;
      logic [5:0] ec;
      n  = (d == 0) ? 1 : 3;
      mw = !dmem_ready;
      lu = 1'b0;
      ex = -1;
      for (int i = 0; i < POOL; i++) begin
        if (m_live[d][i]) begin
          if (m_stage[d][i] == 0) ex = i;
          if (id_valid && m_stage[d][i] < n && m_mr[d][i] && m_rw[d][i] && m_rd[d][i] != 0 &&
              ((id_rs1_en && m_rd[d][i] == int'(id_rs1_addr)) ||
               (id_rs2_en && m_rd[d][i] == int'(id_rs2_addr))))
            lu = 1'b1;
        end
      end
      fl = !mw && !lu && id_valid && branch_taken;
      ec = {mw || lu, mw, lu && !mw, fl, mw, mw};
      s1 = (ex >= 0) ? exp_sel(d, n, m_s1en[d][ex], m_s1[d][ex]) : 0;
      s2 = (ex >= 0) ? exp_sel(d, n, m_s2en[d][ex], m_s2[d][ex]) : 0;
      if (rst) begin
        ec = '0;
        s1 = 0;
        s2 = 0;
        fl = 1'b0;
      end
      chk($sformatf("d%0d_ctl", d), 64'(ctl_obs[d]), 64'(ec));
      chk($sformatf("d%0d_sel1", d), 64'(sel1_obs[d]), 64'(s1));
      chk($sformatf("d%0d_sel2", d), 64'(sel2_obs[d]), 64'(s2));
      chk($sformatf("d%0d_stall_cnt", d), 64'(scnt_obs[d]), 64'(m_stall[d]));
      chk($sformatf("d%0d_flush_cnt", d), 64'(fcnt_obs[d]), 64'(m_flush[d]));

      if (rst) begin
        for (int i = 0; i < POOL; i++) m_live[d][i] = 1'b0;
        m_stall[d] = '0;
        m_flush[d] = '0;
      end else begin
        if (mw) begin
          for (int i = 0; i < POOL; i++)
            if (m_live[d][i] && m_stage[d][i] == n + 1) m_live[d][i] = 1'b0;
        end else begin
          for (int i = 0; i < POOL; i++) begin
            if (m_live[d][i]) begin
              m_stage[d][i]++;
              if (m_stage[d][i] > n + 1) m_live[d][i] = 1'b0;
            end
          end
          placed = 1'b0;
          if (id_valid && !lu) begin
            for (int i = 0; i < POOL; i++) begin
              if (!placed && !m_live[d][i]) begin
                placed        = 1'b1;
                m_live[d][i]  = 1'b1;
                m_stage[d][i] = 0;
                m_rd[d][i]    = int'(id_rd_addr);
                m_rw[d][i]    = id_reg_write;
                m_mr[d][i]    = id_mem_read;
                m_s1en[d][i]  = id_rs1_en;
                m_s1[d][i]    = int'(id_rs1_addr);
                m_s2en[d][i]  = id_rs2_en;
                m_s2[d][i]    = int'(id_rs2_addr);
              end
            end
          end
        end
        m_stall[d] = m_stall[d] + 32'(ec[5]);
        m_flush[d] = m_flush[d] + 32'(fl);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_reg_write = 0; id_mem_read = 0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    branch_taken = 0; dmem_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    nop();
    chk("reset_ctl_n1", 64'(ctl_obs[0]), 64'(0));
    chk("reset_scnt_n1", 64'(scnt_obs[0]), 64'(0));
    tick();

    // 1: ALU chain, forward from M1 then from WB
    do_reset();
    alu(5, 1, 2);                tick();
    alu(6, 5, 1);                tick();
    drive(0, 1, 1, 5, 0, 0, 9, 1, 0, 0, 1);
    chk("t1_sel_m1", 64'(sel1_obs[0]), 64'(1));
    chk("t1_no_stall", 64'(ctl_obs[0][5]), 64'(0));
    tick();
    nop();
    chk("t1_sel_wb", 64'(sel1_obs[0]), 64'(2));
    tick();

    // 2: load-use with one memory stage
    do_reset();
    load(7, 1);                  tick();
    alu(8, 7, 7);
    chk("t2_stall_bubble", 64'(ctl_obs[0]), 64'(6'b101000));
    tick();
    alu(8, 7, 7);
    chk("t2_released", 64'(ctl_obs[0][5]), 64'(0));
    tick();
    nop();
    chk("t2_sel1_wb", 64'(sel1_obs[0]), 64'(2));
    chk("t2_sel2_wb", 64'(sel2_obs[0]), 64'(2));
    chk("t2_stall_cnt", 64'(scnt_obs[0]), 64'(1));
    tick();

    // 3: load-use with three memory stages
    do_reset();
    load(7, 2);                  tick();
    for (int k = 0; k < 3; k++) begin
      alu(8, 7, 0);
      chk($sformatf("t3_stall%0d", k), 64'(ctl_obs[1][5]), 64'(1));
      tick();
    end
    alu(8, 7, 0);
    chk("t3_released", 64'(ctl_obs[1][5]), 64'(0));
    tick();
    nop();
    chk("t3_sel_wb", 64'(sel1_obs[1]), 64'(4));
    chk("t3_stall_cnt", 64'(scnt_obs[1]), 64'(3));
    tick();

    // 4: memory wait with a taken branch in ID
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 3, 0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("t4_freeze%0d", k), 64'(ctl_obs[0]), 64'(6'b110011));
      tick();
    end
    drive(0, 1, 1, 3, 0, 0, 0, 0, 0, 1, 1);
    chk("t4_flush", 64'(ctl_obs[0]), 64'(6'b000100));
    tick();
    nop();
    chk("t4_flush_cnt", 64'(fcnt_obs[0]), 64'(1));
    tick();

    // 5: loads to x0 never create hazards
    do_reset();
    load(0, 1);                  tick();
    alu(1, 0, 0);
    chk("t5_no_stall_n1", 64'(ctl_obs[0][5]), 64'(0));
    chk("t5_no_stall_n3", 64'(ctl_obs[1][5]), 64'(0));
    tick();
    nop();
    chk("t5_sel1", 64'(sel1_obs[0]), 64'(0));
    chk("t5_sel2", 64'(sel2_obs[0]), 64'(0));
    tick();

    // 6: reset in the middle of a load-use stall
    do_reset();
    load(7, 1);                  tick();
    alu(8, 7, 1);
    chk("t6_stalling", 64'(ctl_obs[0][5]), 64'(1));
    tick();
    drive(1, 1, 1, 7, 1, 1, 8, 1, 0, 0, 1);
    tick();
    alu(8, 7, 1);
    chk("t6_ctl_n1", 64'(ctl_obs[0]), 64'(0));
    chk("t6_ctl_n3", 64'(ctl_obs[1]), 64'(0));
    chk("t6_scnt", 64'(scnt_obs[0]), 64'(0));
    tick();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 80),
            ($urandom_range(0, 99) < 75), $urandom_range(0, 3),
            ($urandom_range(0, 99) < 60), $urandom_range(0, 3),
            $urandom_range(0, 3),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 85));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
